// File: rtl/vdp_pkg.sv
// Shared constants and CPU request-buffer state encoding for the VDP VRAM block.
package vdp_pkg;

  localparam int unsigned VRAM_SIZE_DEFAULT = 8 * 1024;
  localparam int unsigned VRAM_DATA_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND_WR = 2'd1,
    PEND_RD = 2'd2
  } cpu_state_e;

endpackage

// File: rtl/vdp_vram_bram.sv
// Single-port synchronous VRAM with registered read data (iCE40 EBR friendly).
module vdp_vram_bram #(
  parameter int unsigned DEPTH = 8 * 1024,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned DW    = 8
) (
  input  logic          pxclk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];

  // One access per clock; read-first, no reset so it maps onto block RAM.
  always_ff @(posedge pxclk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/vdp_vram_ctl.sv
// VRAM owner: display-fetch DMA reads with absolute priority, CPU accesses
// served from a one-entry request buffer in cycles the fetch leaves free.
module vdp_vram_ctl
  import vdp_pkg::*;
#(
  parameter int unsigned VRAM_SIZE       = VRAM_SIZE_DEFAULT,
  parameter int unsigned VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE)
) (
  input  logic                       pxclk,
  input  logic                       reset,
  input  logic [VRAM_ADDR_WIDTH-1:0] vdp_dma_addr,
  input  logic                       vdp_dma_rd_tick,
  output logic [7:0]                 vram_dout,
  input  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]                 cpu_din,
  input  logic                       cpu_wr_req,
  input  logic                       cpu_rd_req,
  output logic [7:0]                 cpu_dout,
  output logic                       cpu_rd_valid,
  output logic                       cpu_busy
);

  localparam int unsigned AW = VRAM_ADDR_WIDTH;
  localparam int unsigned DW = VRAM_DATA_WIDTH;

  cpu_state_e    state_q, state_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [DW-1:0] buf_data_q, buf_data_d;
  logic          busy_d;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic          dma_rd_d, dma_rd_q;
  logic          cpu_rd_d, cpu_rd_q;
  logic [DW-1:0] vram_hold_q;
  logic [DW-1:0] cpu_hold_q;
  logic          busy_q;

  vdp_vram_bram #(
    .DEPTH (VRAM_SIZE),
    .AW    (AW),
    .DW    (DW)
  ) u_bram (
    .pxclk (pxclk),
    .we    (ram_we),
    .addr  (ram_addr),
    .din   (ram_din),
    .dout  (ram_dout)
  );

  // State, request buffer and read-source flags.
  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      busy_q     <= 1'b0;
      dma_rd_q   <= 1'b0;
      cpu_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      busy_q     <= busy_d;
      dma_rd_q   <= dma_rd_d;
      cpu_rd_q   <= cpu_rd_d;
    end
  end

  // Arbitration and CPU buffer FSM; the RAM port follows the DMA address unless the CPU owns the cycle.
  always_comb begin
    state_d    = state_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    ram_we     = 1'b0;
    ram_addr   = vdp_dma_addr;
    ram_din    = buf_data_q;
    dma_rd_d   = vdp_dma_rd_tick;
    cpu_rd_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_wr_req) begin
          state_d    = PEND_WR;
          buf_addr_d = cpu_addr;
          buf_data_d = cpu_din;
        end else if (cpu_rd_req) begin
          state_d    = PEND_RD;
          buf_addr_d = cpu_addr;
        end
      end
      PEND_WR: begin
        if (!vdp_dma_rd_tick) begin
          ram_we   = 1'b1;
          ram_addr = buf_addr_q;
          state_d  = IDLE;
        end
      end
      PEND_RD: begin
        if (!vdp_dma_rd_tick) begin
          ram_addr = buf_addr_q;
          cpu_rd_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Capture the RAM output for the requester that owned the previous cycle so it holds afterwards.
  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) begin
      vram_hold_q <= '0;
      cpu_hold_q  <= '0;
    end else begin
      if (dma_rd_q) begin
        vram_hold_q <= ram_dout;
      end
      if (cpu_rd_q) begin
        cpu_hold_q <= ram_dout;
      end
    end
  end

  // The RAM's own output register gives the one-cycle latency; the hold registers cover the idle cycles.
  assign vram_dout    = dma_rd_q ? ram_dout : vram_hold_q;
  assign cpu_dout     = cpu_rd_q ? ram_dout : cpu_hold_q;
  assign cpu_rd_valid = cpu_rd_q;
  assign cpu_busy     = busy_q;

endmodule

// File: tb/tb_vdp_vram_ctl.sv
// Self-checking bench for vdp_vram_ctl: reference model plus scoreboard queues.
module tb_vdp_vram_ctl;

  localparam int unsigned SIZE = 8192;
  localparam int unsigned AW   = 13;
  localparam int MS_IDLE = 0;
  localparam int MS_WR   = 1;
  localparam int MS_RD   = 2;

  logic          pxclk = 1'b0;
  logic          reset;
  logic [AW-1:0] dma_addr;
  logic          tick;
  logic [7:0]    vram_dout;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_wr_req;
  logic          cpu_rd_req;
  logic [7:0]    cpu_dout;
  logic          cpu_rd_valid;
  logic          cpu_busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]    mem_m [SIZE];
  bit            wr_m  [SIZE];
  int            m_state;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_data;
  int            m_age;
  logic [7:0]    vram_exp;
  bit            vram_known;
  logic [7:0]    cpu_exp;
  bit            cpu_known;

  // Scoreboard queues: bit 8 marks whether the expected byte is defined
  logic [8:0]    dma_q [$];
  logic [8:0]    rd_q  [$];

  always #20 pxclk = ~pxclk;

  vdp_vram_ctl dut (
    .pxclk           (pxclk),
    .reset           (reset),
    .vdp_dma_addr    (dma_addr),
    .vdp_dma_rd_tick (tick),
    .vram_dout       (vram_dout),
    .cpu_addr        (cpu_addr),
    .cpu_din         (cpu_din),
    .cpu_wr_req      (cpu_wr_req),
    .cpu_rd_req      (cpu_rd_req),
    .cpu_dout        (cpu_dout),
    .cpu_rd_valid    (cpu_rd_valid),
    .cpu_busy        (cpu_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state    = MS_IDLE;
    m_age      = 0;
    vram_exp   = 8'h00;
    vram_known = 1'b1;
    cpu_exp    = 8'h00;
    cpu_known  = 1'b1;
    dma_q.delete();
    rd_q.delete();
  endtask

  // One clock: model the edge from the current inputs, then compare the DUT just after it.
  task automatic cyc();
    bit            t;
    bit            rdv_exp;
    logic [AW-1:0] da;
    logic [8:0]    e;
    t       = tick;
    da      = dma_addr;
    rdv_exp = 1'b0;
    if (t) dma_q.push_back({wr_m[da], mem_m[da]});
    case (m_state)
      MS_IDLE: begin
        if (cpu_wr_req) begin
          m_state = MS_WR; m_addr = cpu_addr; m_data = cpu_din; m_age = 0;
        end else if (cpu_rd_req) begin
          m_state = MS_RD; m_addr = cpu_addr; m_age = 0;
        end
      end
      MS_WR: begin
        if (!t) begin
          check("wr_service_age", 32'(m_age <= 16), 32'd1);
          mem_m[m_addr] = m_data;
          wr_m[m_addr]  = 1'b1;
          m_state       = MS_IDLE;
        end
      end
      MS_RD: begin
        if (!t) begin
          check("rd_service_age", 32'(m_age <= 16), 32'd1);
          rd_q.push_back({wr_m[m_addr], mem_m[m_addr]});
          rdv_exp = 1'b1;
          m_state = MS_IDLE;
        end
      end
      default: m_state = MS_IDLE;
    endcase
    if (m_state != MS_IDLE) m_age++;

    @(posedge pxclk);
    #1;
    cpu_wr_req = 1'b0;
    cpu_rd_req = 1'b0;
    if (t) begin
      e          = dma_q.pop_front();
      vram_exp   = e[7:0];
      vram_known = e[8];
    end
    if (rdv_exp) begin
      e         = rd_q.pop_front();
      cpu_exp   = e[7:0];
      cpu_known = e[8];
    end
    check("cpu_busy", 32'(cpu_busy), 32'(m_state != MS_IDLE));
    check("cpu_rd_valid", 32'(cpu_rd_valid), 32'(rdv_exp));
    if (vram_known) check("vram_dout", 32'(vram_dout), 32'(vram_exp));
    if (cpu_known) check("cpu_dout", 32'(cpu_dout), 32'(cpu_exp));
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
    cpu_addr   = a;
    cpu_din    = d;
    cpu_wr_req = 1'b1;
    cyc();
  endtask

  task automatic dma_read(input logic [AW-1:0] a);
    tick     = 1'b1;
    dma_addr = a;
    cyc();
    tick = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_vram_dout"}, 32'(vram_dout), 32'd0);
    check({tag, "_cpu_dout"}, 32'(cpu_dout), 32'd0);
    check({tag, "_cpu_rd_valid"}, 32'(cpu_rd_valid), 32'd0);
    check({tag, "_cpu_busy"}, 32'(cpu_busy), 32'd0);
  endtask

  function automatic logic [AW-1:0] soak_addr(input int i);
    if (i < 8) return AW'(i);
    return AW'(13'h1FF8 + 13'(i - 8));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset      = 1'b0;
    tick       = 1'b0;
    dma_addr   = '0;
    cpu_addr   = '0;
    cpu_din    = '0;
    cpu_wr_req = 1'b0;
    cpu_rd_req = 1'b0;
    model_reset();
    #1;
    check_outputs_zero("por");
    repeat (2) @(posedge pxclk);
    #1;
    reset = 1'b1;
    cyc();

    // Write then DMA read, held afterwards
    cpu_write(13'h0123, 8'hA5);
    cyc();
    dma_read(13'h0123);
    check("wr_then_dma", 32'(vram_dout), 32'h0A5);
    repeat (3) cyc();
    check("wr_then_dma_hold", 32'(vram_dout), 32'h0A5);

    // DMA starvation: write stays pending across five tick cycles
    tick     = 1'b1;
    dma_addr = 13'h0123;
    cpu_write(13'h0001, 8'h5A);
    repeat (4) cyc();
    check("starve_busy", 32'(cpu_busy), 32'd1);
    tick = 1'b0;
    cyc();
    check("starve_commit_busy", 32'(cpu_busy), 32'd0);
    dma_read(13'h0001);
    check("starve_data", 32'(vram_dout), 32'h05A);

    // CPU read latency at the top address
    cpu_write(13'h1FFF, 8'h3C);
    cyc();
    cpu_addr   = 13'h1FFF;
    cpu_rd_req = 1'b1;
    cyc();
    check("rd_lat_t1", 32'(cpu_rd_valid), 32'd0);
    cyc();
    check("rd_lat_t2_valid", 32'(cpu_rd_valid), 32'd1);
    check("rd_lat_t2_data", 32'(cpu_dout), 32'h03C);
    cyc();
    check("rd_lat_t3", 32'(cpu_rd_valid), 32'd0);

    // Collision: write wins, read dropped
    cpu_addr   = 13'h0040;
    cpu_din    = 8'h77;
    cpu_wr_req = 1'b1;
    cpu_rd_req = 1'b1;
    cyc();
    repeat (3) cyc();
    dma_read(13'h0040);
    check("collision_data", 32'(vram_dout), 32'h077);

    // Overrun: requests while busy and in the completion cycle are ignored
    tick     = 1'b1;
    dma_addr = 13'h0123;
    cpu_write(13'h0050, 8'h11);
    cpu_write(13'h0050, 8'h22);
    cpu_addr   = 13'h0050;
    cpu_rd_req = 1'b1;
    cyc();
    tick = 1'b0;
    cpu_write(13'h0050, 8'h33);
    repeat (2) cyc();
    dma_read(13'h0050);
    check("overrun_data", 32'(vram_dout), 32'h011);

    // Reset mid-operation discards a pending write
    tick     = 1'b1;
    dma_addr = 13'h0040;
    cpu_write(13'h0040, 8'hEE);
    cyc();
    #3;
    reset = 1'b0;
    tick  = 1'b0;
    #1;
    check_outputs_zero("rst_async");
    model_reset();
    @(posedge pxclk);
    #1;
    check_outputs_zero("rst_held");
    reset = 1'b1;
    cyc();
    check("rst_release_busy", 32'(cpu_busy), 32'd0);
    check("rst_release_vram", 32'(vram_dout), 32'd0);
    dma_read(13'h0040);
    check("rst_no_write", 32'(vram_dout), 32'h077);

    // Soak: fetch pattern 2 on / 2 off / 2 on / 10 off with random CPU traffic
    for (int i = 0; i < 16; i++) begin
      cpu_write(soak_addr(i), 8'($urandom));
      cyc();
    end
    for (int k = 0; k < 40; k++) begin
      for (int p = 0; p < 16; p++) begin
        tick     = (p < 2) || (p >= 4 && p < 6);
        dma_addr = soak_addr(int'($urandom_range(0, 15)));
        r        = int'($urandom_range(0, 5));
        cpu_addr = soak_addr(int'($urandom_range(0, 15)));
        cpu_din  = 8'($urandom);
        cpu_wr_req = (r == 0) || (r == 2);
        cpu_rd_req = (r == 1) || (r == 2);
        cyc();
      end
    end
    tick = 1'b0;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
